// File: rtl/ikbd_pkg.sv
// Shared types and constants for the IKBD key-matrix scanner: matrix geometry,
// scan FSM states and the 8-bit key event code.
package ikbd_pkg;

  localparam int NUM_COLS = 15;
  localparam int NUM_ROWS = 8;
  localparam int COL_W    = 4;
  localparam int ROW_W    = 3;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } scan_state_e;

  typedef logic [7:0] ikbd_code_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [ROW_W-1:0] lowest_set(input logic [NUM_ROWS-1:0] bits);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (bits[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

  // {col,row} packs to col*8+row because a column spans exactly eight rows.
  function automatic ikbd_code_t make_code(input logic             is_release,
                                           input logic [COL_W-1:0] col,
                                           input logic [ROW_W-1:0] row);
    return {is_release, col, row};
  endfunction

endpackage

// File: rtl/ikbd_code_fifo.sv
// Synchronous first-word-fall-through FIFO for key event codes, with an
// occupancy output. A push while full is refused; a pop frees space next cycle.
module ikbd_code_fifo
  import ikbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_code,
  input  logic       pop,
  output logic [7:0] head_code,
  output logic       head_valid,
  output logic       full,
  output logic [5:0] level
);

  localparam int AW = $clog2(DEPTH);

  ikbd_code_t    mem_q [DEPTH];
  ikbd_code_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [5:0]    level_q, level_d;
  logic          do_push, do_pop;

  assign full       = (level_q == 6'(DEPTH));
  assign head_valid = (level_q != 6'd0);
  assign head_code  = head_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level      = level_q;
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  // NOTE: every signal written here gets a default first, so no path can hold
  // a stale value and infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 6'd1;
      2'b01:   level_d = level_q - 6'd1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; an entry is only ever read
  // after being written, and head_code is forced to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ikbd_matrix_scan.sv
// IKBD key-matrix scanner: samples one column every SCAN_DIV+2 clocks, compares
// it with the last reported state and queues press/release codes in a FIFO.
module ikbd_matrix_scan
  import ikbd_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  matrix,
  output logic [7:0]                         code,
  output logic                               code_valid,
  input  logic                               code_ready,
  output logic [5:0]                         fifo_level
);

  localparam int DIV_W = 10;

  scan_state_e                      state_q, state_d;
  logic [DIV_W-1:0]                 div_q, div_d;
  logic [COL_W-1:0]                 col_q, col_d;
  logic [NUM_ROWS-1:0]              sample_q, sample_d;
  logic [NUM_ROWS-1:0]              diff_q, diff_d;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] snapshot_q, snapshot_d;

  logic             fifo_full;
  logic             push;
  ikbd_code_t       push_code;
  logic [ROW_W-1:0] emit_row;

  assign emit_row = lowest_set(diff_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    col_d      = col_q;
    sample_d   = sample_q;
    diff_d     = diff_q;
    snapshot_d = snapshot_q;
    push       = 1'b0;
    push_code  = make_code(sample_q[emit_row], col_q, emit_row);

    unique case (state_q)
      ST_WAIT: begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d   = '0;
          state_d = ST_LOAD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LOAD: begin
        sample_d = matrix[col_q];
        diff_d   = matrix[col_q] ^ snapshot_q[col_q];
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        if (diff_q == '0) begin
          col_d   = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
          state_d = ST_WAIT;
        end else if (!fifo_full) begin
          // A full FIFO freezes diff and snapshot so the event is retried intact.
          push                         = 1'b1;
          snapshot_d[col_q][emit_row]  = sample_q[emit_row];
          diff_d[emit_row]             = 1'b0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      div_q      <= '0;
      col_q      <= '0;
      sample_q   <= '1;
      diff_q     <= '0;
      snapshot_q <= '1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      col_q      <= col_d;
      sample_q   <= sample_d;
      diff_q     <= diff_d;
      snapshot_q <= snapshot_d;
    end
  end

  ikbd_code_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_code  (push_code),
    .pop        (code_ready),
    .head_code  (code),
    .head_valid (code_valid),
    .full       (fifo_full),
    .level      (fifo_level)
  );

endmodule

// File: tb/tb_ikbd_matrix_scan.sv
// Self-checking bench for ikbd_matrix_scan: directed scenarios plus randomized
// single-column changes, checked against an event-list model of key state.
module tb_ikbd_matrix_scan;
  import ikbd_pkg::*;

  localparam int S      = 5;
  localparam int DEPTH  = 8;
  localparam int PERIOD = NUM_COLS * (S + 2);

  logic                              clk = 1'b0;
  logic                              reset;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] matrix;
  logic [7:0]                        code;
  logic                              code_valid;
  logic                              code_ready;
  logic [5:0]                        fifo_level;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] model_snap [NUM_COLS];
  int         valid_cycles = 0;
  int         max_level = 0;

  ikbd_matrix_scan #(
    .SCAN_DIV   (S),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .matrix     (matrix),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_level (fifo_level)
  );

  initial forever #5 clk = ~clk;

  // Consumer-side monitor: records each code at the moment it is accepted.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (code_valid) valid_cycles++;
      if (code_valid && code_ready) got_q.push_back(code);
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reported state after reset is "all released", so every held key is a press.
  task automatic model_from_reset();
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!matrix[c][r]) exp_q.push_back({1'b0, 7'(c * 8 + r)});
      end
      model_snap[c] = matrix[c];
    end
  endtask

  // One column changes atomically, so its events come out together, rows ascending.
  task automatic set_col(input int c, input logic [7:0] v);
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (v[r] !== model_snap[c][r]) exp_q.push_back({v[r], 7'(c * 8 + r)});
    end
    model_snap[c] = v;
    matrix[c]     = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    tick(1);
    got_q.delete();
    exp_q.delete();
    valid_cycles = 0;
    max_level    = 0;
    model_from_reset();
    tick(1);
    reset = 1'b0;
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_code%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         n;
    int         c;
    int         r;
    logic [7:0] v;

    reset      = 1'b1;
    code_ready = 1'b1;
    matrix     = '1;

    // Reset state and idle scans.
    do_reset();
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_code", 32'(code), 32'h00);
    tick(3 * PERIOD);
    check("idle_valid_cycles", 32'(valid_cycles), 32'd0);
    check("idle_fifo_level", 32'(fifo_level), 32'd0);
    check_events("idle");

    // Single key 'a' press then release.
    set_col(4, 8'hdf);
    tick(2 * PERIOD);
    check_events("key_a_press");
    set_col(4, 8'hff);
    tick(2 * PERIOD);
    check_events("key_a_release");

    // Two keys in one column: ascending row order.
    set_col(1, 8'hde);
    tick(2 * PERIOD);
    check_events("col1_pair");
    set_col(1, 8'hff);
    tick(2 * PERIOD);
    check_events("col1_pair_release");

    // First-event latency from reset for a random key: c clean columns then WAIT+LOAD+EMIT.
    c = $urandom_range(0, NUM_COLS - 1);
    r = $urandom_range(0, NUM_ROWS - 1);
    matrix[c][r] = 1'b0;
    do_reset();
    n = 0;
    while (!code_valid && n < 2 * PERIOD) begin
      tick(1);
      n++;
    end
    check($sformatf("latency_col%0d", c), 32'(n), 32'(c * (S + 2) + S + 2));
    tick(PERIOD);
    check_events("latency_event");
    set_col(c, 8'hff);
    tick(2 * PERIOD);
    check_events("latency_release");

    // Backpressure: 10 presses with the consumer stalled.
    code_ready = 1'b0;
    matrix[13] = 8'h00;
    matrix[14] = 8'hfc;
    do_reset();
    tick(3 * PERIOD);
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    check("full_no_pops", 32'(got_q.size()), 32'd0);
    tick(PERIOD);
    check("full_stalled_level", 32'(fifo_level), 32'(DEPTH));
    code_ready = 1'b1;
    tick(2 * PERIOD);
    check_events("full_drain");
    check("full_max_level", 32'(max_level), 32'(DEPTH));
    set_col(13, 8'hff);
    tick(2 * PERIOD);
    check_events("col13_release");
    set_col(14, 8'hff);
    tick(2 * PERIOD);
    check_events("col14_release");

    // Reset landing in the EMIT cycle of column 0 with a key held.
    matrix[0] = 8'hef;
    do_reset();
    tick(S + 1);
    reset = 1'b1;
    tick(1);
    got_q.delete();
    exp_q.delete();
    model_from_reset();
    tick(1);
    reset = 1'b0;
    check("mid_emit_rst_level", 32'(fifo_level), 32'd0);
    tick(2 * PERIOD);
    check_events("mid_emit_rst");
    set_col(0, 8'hff);
    tick(2 * PERIOD);
    check_events("mid_emit_release");

    // A glitch between two samples of column 14 is invisible; a held press is not.
    do_reset();
    tick(2 * (S + 2));
    matrix[14][7] = 1'b0;
    tick(10);
    matrix[14][7] = 1'b1;
    tick(2 * PERIOD);
    check("glitch_no_event", 32'(got_q.size()), 32'd0);
    check("glitch_level", 32'(fifo_level), 32'd0);
    got_q.delete();
    set_col(14, 8'h7f);
    tick(2 * PERIOD);
    check_events("col14_held");
    set_col(14, 8'hff);
    tick(2 * PERIOD);
    check_events("col14_held_release");

    // Randomized single-column changes with a randomly stalling consumer.
    for (int it = 0; it < 20; it++) begin
      c = $urandom_range(0, NUM_COLS - 1);
      v = model_snap[c] ^ 8'($urandom_range(1, 255));
      set_col(c, v);
      for (int k = 0; k < 3 * PERIOD; k++) begin
        code_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
      code_ready = 1'b1;
      tick(PERIOD);
      check_events($sformatf("rand%0d_col%0d", it, c));
    end

    check("final_level", 32'(fifo_level), 32'd0);
    check("final_code_valid", 32'(code_valid), 32'd0);
    check("level_never_above_depth", 32'(max_level <= DEPTH), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ikbd_matrix_scan.md
IKBD_MATRIX_SCAN -- requirements
Module: ikbd_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clocks spent in WAIT before each column sample (legal range 1..1023).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries (power of two, 2..32).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port matrix  input  [7:0] x15  key matrix, column 0..14, row bit 0..7, 0 = pressed, 1 = released.
REQ-006 SHALL have port code  output  8  event code at FIFO head: bit7 = release (1) / press (0), bits6:0 = col*8+row.
REQ-007 SHALL have port code_valid  output  1  FIFO not empty.
REQ-008 SHALL have port code_ready  input  1  consumer accepts code; pop when code_valid && code_ready.
REQ-009 SHALL have port fifo_level  output  6  current FIFO occupancy.

Function
REQ-010 SHALL hold a 15x8 snapshot of the last reported key state.
REQ-011 SHALL run FSM WAIT -> LOAD -> EMIT -> WAIT.
REQ-012 WAIT SHALL count SCAN_DIV clocks, then enter LOAD.
REQ-013 LOAD SHALL latch matrix[col] into sample and form diff = sample ^ snapshot[col] in one cycle, then enter EMIT.
REQ-014 EMIT SHALL, per cycle, select the lowest set diff bit r and, if FIFO not full, push {sample[r], col*8+r}, set snapshot[col][r] = sample[r] and clear diff[r].
REQ-015 EMIT with FIFO full SHALL stall: no push, no snapshot or diff change, so no event is lost or duplicated.
REQ-016 EMIT with diff == 0 SHALL advance col (14 wraps to 0) and enter WAIT; a column with no change therefore costs exactly one EMIT cycle.
REQ-017 Matrix changes after LOAD SHALL be ignored until that column is next sampled.
REQ-018 Events within one column SHALL be emitted in ascending row order; columns in ascending order.
REQ-019 FIFO SHALL be first-word-fall-through: code valid in the same cycle code_valid is high; push to empty FIFO visible one clock later.
REQ-020 Simultaneous push and pop SHALL be permitted at any level including full (pop frees a slot only for the next cycle; push while full is blocked per REQ-015).
REQ-021 fifo_level SHALL equal pushes minus pops, never exceeding FIFO_DEPTH.
REQ-022 Full scan period SHALL be 15*(SCAN_DIV+2) clocks when no events and no stalls.

Reset
REQ-023 Reset SHALL set snapshot to all 1s, col = 0, FSM = WAIT with divider = 0, diff = 0, FIFO empty, code_valid = 0, fifo_level = 0, code = 8'h00.
REQ-024 Reset asserted mid-EMIT SHALL discard pending diff bits; keys held through reset SHALL be reported as presses on the first post-reset scan.
REQ-025 Reset SHALL take priority over all other activity in the same cycle.

Structure
REQ-026 Shared package ikbd_pkg SHALL hold NUM_COLS = 15, NUM_ROWS = 8, the FSM state enum and the 8-bit event code type.
REQ-027 FIFO SHALL be a separate sub-module ikbd_code_fifo (sync FWFT, parameter DEPTH, level output).
REQ-028 Matrix, snapshot and diff storage SHALL be flops; no inferred RAM.

Verification
REQ-029 Reset, matrix all 8'hff, 3 full scans -> code_valid stays 0, fifo_level 0.
REQ-030 matrix[4][5] = 0 ('a'), code_ready = 1 -> single code 8'h25; then matrix[4][5] = 1 -> single code 8'hA5.
REQ-031 matrix[1][5] = 0 and matrix[1][0] = 0 in same scan -> codes 8'h08 then 8'h0D, in that order.
REQ-032 code_ready = 0, press 10 keys in column 13 (rows 0..7) and column 14 (rows 0,1) -> fifo_level saturates at 8, scan stalls; raise code_ready -> all 10 codes 8'h68..8'h6F, 8'h70, 8'h71 received once each, in order.
REQ-033 Hold matrix[0][4] = 0, assert reset during EMIT of column 0, release reset -> exactly one 8'h04, no 8'h84.
REQ-034 Press and release matrix[14][7] between two samples of column 14 -> no event; press held across a sample -> 8'h77.
